// File: rtl/atm_account_bank.sv
// Bank-side account responder for the ATM front end: linear-search account table
// serving find/auth/balance/withdraw/transfer over a single-outstanding request port.
module atm_account_bank #(
    parameter int unsigned NUM_ACCOUNTS = 8,
    parameter int unsigned ACC_W        = 12,
    parameter int unsigned PIN_W        = 4,
    parameter int unsigned BAL_W        = 11,
    parameter int unsigned INIT_BALANCE = 500
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [3:0]       load_idx,
    input  logic [ACC_W-1:0] load_acc,
    input  logic [PIN_W-1:0] load_pin,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [ACC_W-1:0] req_acc,
    input  logic [PIN_W-1:0] req_pin,
    input  logic [ACC_W-1:0] req_dest,
    input  logic [BAL_W-1:0] req_amount,
    output logic             rsp_valid,
    output logic             rsp_error,
    output logic [2:0]       rsp_code,
    output logic [BAL_W-1:0] rsp_balance
);
    localparam int unsigned IDX_W = $clog2(NUM_ACCOUNTS);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SEARCH_SRC = 3'd1;
    localparam logic [2:0] S_SEARCH_DST = 3'd2;
    localparam logic [2:0] S_EXECUTE    = 3'd3;
    localparam logic [2:0] S_RESPOND    = 3'd4;

    localparam logic [2:0] OP_FIND     = 3'd0;
    localparam logic [2:0] OP_WITHDRAW = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;

    localparam logic [2:0] C_OK        = 3'd0;
    localparam logic [2:0] C_NOT_FOUND = 3'd1;
    localparam logic [2:0] C_BAD_PIN   = 3'd2;
    localparam logic [2:0] C_INSUFF    = 3'd3;
    localparam logic [2:0] C_OVERFLOW  = 3'd4;
    localparam logic [2:0] C_BAD_OP    = 3'd5;
    localparam logic [2:0] C_SAME_ACC  = 3'd6;

    logic [2:0]       state, state_nxt;
    logic [IDX_W-1:0] idx, src_idx, dst_idx;
    logic [2:0]       op_q, pre_code;
    logic [ACC_W-1:0] acc_q, dest_q;
    logic [PIN_W-1:0] pin_q;
    logic [BAL_W-1:0] amount_q;

    logic [NUM_ACCOUNTS-1:0] tab_valid;
    logic [ACC_W-1:0]        tab_acc [NUM_ACCOUNTS];
    logic [PIN_W-1:0]        tab_pin [NUM_ACCOUNTS];
    logic [BAL_W-1:0]        tab_bal [NUM_ACCOUNTS];

    logic             accept_c, load_ok_c, hit_src_c, hit_dst_c, last_c;
    logic             moves_money_c, wr_src_c, wr_dst_c;
    logic [BAL_W-1:0] src_bal_c, dst_bal_c, exec_bal_c;
    logic [BAL_W:0]   dst_sum_c;
    logic [2:0]       exec_code_c;

    assign req_ready = (state == S_IDLE) && !load_en;
    assign accept_c  = req_valid && req_ready;
    assign load_ok_c = (state == S_IDLE) && load_en && (32'(load_idx) < NUM_ACCOUNTS);
    assign hit_src_c = tab_valid[idx] && (tab_acc[idx] == acc_q);
    assign hit_dst_c = tab_valid[idx] && (tab_acc[idx] == dest_q);
    assign last_c    = (idx == IDX_W'(NUM_ACCOUNTS - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept_c) state_nxt = (req_op > OP_TRANSFER) ? S_EXECUTE : S_SEARCH_SRC;
            S_SEARCH_SRC: begin
                if (hit_src_c)   state_nxt = (op_q == OP_TRANSFER) ? S_SEARCH_DST : S_EXECUTE;
                else if (last_c) state_nxt = S_EXECUTE;
            end
            S_SEARCH_DST: if (hit_dst_c || last_c) state_nxt = S_EXECUTE;
            S_EXECUTE:    state_nxt = S_RESPOND;
            S_RESPOND:    state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // Execute-stage checks in priority order; the destination sum keeps its carry bit
    always_comb begin
        src_bal_c     = tab_bal[src_idx];
        dst_bal_c     = tab_bal[dst_idx];
        dst_sum_c     = {1'b0, dst_bal_c} + {1'b0, amount_q};
        moves_money_c = (op_q == OP_WITHDRAW) || (op_q == OP_TRANSFER);
        exec_code_c   = C_OK;
        wr_src_c      = 1'b0;
        wr_dst_c      = 1'b0;
        if (pre_code != C_OK)                                    exec_code_c = pre_code;
        else if (op_q != OP_FIND && tab_pin[src_idx] != pin_q)   exec_code_c = C_BAD_PIN;
        else if (op_q == OP_TRANSFER && src_idx == dst_idx)      exec_code_c = C_SAME_ACC;
        else if (moves_money_c && amount_q > src_bal_c)          exec_code_c = C_INSUFF;
        else if (op_q == OP_TRANSFER && dst_sum_c[BAL_W])        exec_code_c = C_OVERFLOW;
        else begin
            wr_src_c = moves_money_c;
            wr_dst_c = (op_q == OP_TRANSFER);
        end
        if (exec_code_c == C_NOT_FOUND || exec_code_c == C_BAD_PIN || exec_code_c == C_BAD_OP)
            exec_bal_c = '0;
        else if (wr_src_c)
            exec_bal_c = src_bal_c - amount_q;
        else
            exec_bal_c = src_bal_c;
    end

    // Request capture, search index and account table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            src_idx   <= '0;
            dst_idx   <= '0;
            op_q      <= '0;
            pre_code  <= C_OK;
            acc_q     <= '0;
            dest_q    <= '0;
            pin_q     <= '0;
            amount_q  <= '0;
            tab_valid <= '0;
            for (int i = 0; i < int'(NUM_ACCOUNTS); i++) begin
                tab_acc[i] <= '0;
                tab_pin[i] <= '0;
                tab_bal[i] <= BAL_W'(INIT_BALANCE);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_ok_c) begin
                        tab_valid[load_idx[IDX_W-1:0]] <= 1'b1;
                        tab_acc[load_idx[IDX_W-1:0]]   <= load_acc;
                        tab_pin[load_idx[IDX_W-1:0]]   <= load_pin;
                        tab_bal[load_idx[IDX_W-1:0]]   <= BAL_W'(INIT_BALANCE);
                    end
                    if (accept_c) begin
                        idx      <= '0;
                        op_q     <= req_op;
                        acc_q    <= req_acc;
                        pin_q    <= req_pin;
                        dest_q   <= req_dest;
                        amount_q <= req_amount;
                        pre_code <= (req_op > OP_TRANSFER) ? C_BAD_OP : C_OK;
                    end
                end
                S_SEARCH_SRC: begin
                    if (hit_src_c) begin
                        src_idx <= idx;
                        idx     <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                        if (last_c) pre_code <= C_NOT_FOUND;
                    end
                end
                S_SEARCH_DST: begin
                    idx <= idx + 1'b1;
                    if (hit_dst_c)   dst_idx  <= idx;
                    else if (last_c) pre_code <= C_NOT_FOUND;
                end
                S_EXECUTE: begin
                    if (wr_src_c) tab_bal[src_idx] <= src_bal_c - amount_q;
                    if (wr_dst_c) tab_bal[dst_idx] <= dst_sum_c[BAL_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Response registers: pulse on the execute edge, payload held until the next response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_code    <= C_OK;
            rsp_balance <= '0;
        end else begin
            rsp_valid <= (state == S_EXECUTE);
            if (state == S_EXECUTE) begin
                rsp_code    <= exec_code_c;
                rsp_error   <= (exec_code_c != C_OK);
                rsp_balance <= exec_bal_c;
            end
        end
    end
endmodule

// File: tb/tb_atm_account_bank.sv
// Directed bench for atm_account_bank; a second instance with a 1500 opening balance covers overflow.
module tb_atm_account_bank;
    localparam int unsigned ACC_W = 12;
    localparam int unsigned PIN_W = 4;
    localparam int unsigned BAL_W = 11;

    localparam logic [2:0] FIND = 3'd0, AUTH = 3'd1, BALANCE = 3'd2, WITHDRAW = 3'd3, TRANSFER = 3'd4;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_en;
    logic [3:0]       load_idx;
    logic [ACC_W-1:0] load_acc;
    logic [PIN_W-1:0] load_pin;
    logic             req_valid;
    logic [2:0]       req_op;
    logic [ACC_W-1:0] req_acc, req_dest;
    logic [PIN_W-1:0] req_pin;
    logic [BAL_W-1:0] req_amount;

    logic             req_ready, rsp_valid, rsp_error;
    logic [2:0]       rsp_code;
    logic [BAL_W-1:0] rsp_balance;
    logic             hi_req_ready, hi_rsp_valid, hi_rsp_error;
    logic [2:0]       hi_rsp_code;
    logic [BAL_W-1:0] hi_rsp_balance;

    int checks = 0;
    int errors = 0;

    int             lat;
    logic [2:0]     code, hi_code;
    logic [BAL_W-1:0] bal, hi_bal;
    logic           err;

    always #5 clk = ~clk;

    atm_account_bank u_dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_acc(load_acc), .load_pin(load_pin), .req_valid(req_valid),
        .req_ready(req_ready), .req_op(req_op), .req_acc(req_acc), .req_pin(req_pin),
        .req_dest(req_dest), .req_amount(req_amount), .rsp_valid(rsp_valid),
        .rsp_error(rsp_error), .rsp_code(rsp_code), .rsp_balance(rsp_balance)
    );

    atm_account_bank #(.INIT_BALANCE(1500)) u_dut_hi (
        .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_acc(load_acc), .load_pin(load_pin), .req_valid(req_valid),
        .req_ready(hi_req_ready), .req_op(req_op), .req_acc(req_acc), .req_pin(req_pin),
        .req_dest(req_dest), .req_amount(req_amount), .rsp_valid(hi_rsp_valid),
        .rsp_error(hi_rsp_error), .rsp_code(hi_rsp_code), .rsp_balance(hi_rsp_balance)
    );

    task automatic load(input logic [3:0] i, input logic [ACC_W-1:0] a, input logic [PIN_W-1:0] p);
        @(negedge clk);
        load_en = 1'b1; load_idx = i; load_acc = a; load_pin = p;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Issue one request and wait (bounded) for the response pulse; lat is -1 on timeout
    task automatic send(input logic [2:0] op, input logic [ACC_W-1:0] a, input logic [PIN_W-1:0] p,
                        input logic [ACC_W-1:0] d, input logic [BAL_W-1:0] amt);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_acc = a; req_pin = p; req_dest = d; req_amount = amt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (rsp_valid) begin
                lat = n; code = rsp_code; bal = rsp_balance; err = rsp_error;
                hi_code = hi_rsp_code; hi_bal = hi_rsp_balance;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_en = 1'b0; load_idx = '0; load_acc = '0; load_pin = '0;
        req_valid = 1'b0; req_op = '0; req_acc = '0; req_pin = '0; req_dest = '0; req_amount = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_code !== 3'd0 || rsp_error !== 1'b0) begin errors++; $display("FAIL reset_code got %0d/%b want 0/0", rsp_code, rsp_error); end
        checks++; if (rsp_balance !== 11'd0) begin errors++; $display("FAIL reset_balance got %0d want 0", rsp_balance); end
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_setup();
        load(4'd0, 12'd2178, 4'd4);
        load(4'd3, 12'd2816, 4'd6);
        send(AUTH, 12'd2278, 4'd4, 12'd0, 11'd0);
        checks++; if (lat !== 9 || code !== 3'd1 || bal !== 11'd0 || err !== 1'b1) begin errors++;
            $display("FAIL auth_not_found got lat %0d code %0d bal %0d err %b want 9 1 0 1", lat, code, bal, err); end
        send(AUTH, 12'd2178, 4'd5, 12'd0, 11'd0);
        checks++; if (lat !== 2 || code !== 3'd2 || bal !== 11'd0) begin errors++;
            $display("FAIL auth_bad_pin got lat %0d code %0d bal %0d want 2 2 0", lat, code, bal); end
        send(AUTH, 12'd2178, 4'd4, 12'd0, 11'd0);
        checks++; if (lat !== 2 || code !== 3'd0 || bal !== 11'd500 || err !== 1'b0) begin errors++;
            $display("FAIL auth_ok got lat %0d code %0d bal %0d err %b want 2 0 500 0", lat, code, bal, err); end
    endtask

    task automatic test_withdraw();
        send(WITHDRAW, 12'd2178, 4'd4, 12'd0, 11'd100);
        checks++; if (lat !== 2 || code !== 3'd0 || bal !== 11'd400) begin errors++;
            $display("FAIL withdraw_ok got lat %0d code %0d bal %0d want 2 0 400", lat, code, bal); end
        send(WITHDRAW, 12'd2178, 4'd4, 12'd0, 11'd2000);
        checks++; if (code !== 3'd3 || bal !== 11'd400 || err !== 1'b1) begin errors++;
            $display("FAIL withdraw_insuff got code %0d bal %0d err %b want 3 400 1", code, bal, err); end
        send(BALANCE, 12'd2178, 4'd4, 12'd0, 11'd0);
        checks++; if (lat !== 2 || code !== 3'd0 || bal !== 11'd400) begin errors++;
            $display("FAIL balance_after_wd got lat %0d code %0d bal %0d want 2 0 400", lat, code, bal); end
    endtask

    task automatic test_transfer();
        send(TRANSFER, 12'd2178, 4'd4, 12'd2816, 11'd50);
        checks++; if (lat !== 6 || code !== 3'd0 || bal !== 11'd350) begin errors++;
            $display("FAIL transfer_ok got lat %0d code %0d bal %0d want 6 0 350", lat, code, bal); end
        send(BALANCE, 12'd2816, 4'd6, 12'd0, 11'd0);
        checks++; if (lat !== 5 || code !== 3'd0 || bal !== 11'd550) begin errors++;
            $display("FAIL balance_dst got lat %0d code %0d bal %0d want 5 0 550", lat, code, bal); end
        send(FIND, 12'd2816, 4'd0, 12'd0, 11'd0);
        checks++; if (lat !== 5 || code !== 3'd0 || bal !== 11'd550) begin errors++;
            $display("FAIL find_no_pin got lat %0d code %0d bal %0d want 5 0 550", lat, code, bal); end
        send(WITHDRAW, 12'd2178, 4'd4, 12'd0, 11'd0);
        checks++; if (code !== 3'd0 || bal !== 11'd350) begin errors++;
            $display("FAIL withdraw_zero got code %0d bal %0d want 0 350", code, bal); end
        send(TRANSFER, 12'd2178, 4'd4, 12'd999, 11'd10);
        checks++; if (lat !== 10 || code !== 3'd1 || bal !== 11'd0) begin errors++;
            $display("FAIL transfer_dst_miss got lat %0d code %0d bal %0d want 10 1 0", lat, code, bal); end
    endtask

    task automatic test_bad_op();
        send(3'd6, 12'd2178, 4'd4, 12'd0, 11'd0);
        checks++; if (lat !== 1 || code !== 3'd5 || bal !== 11'd0 || err !== 1'b1) begin errors++;
            $display("FAIL bad_op got lat %0d code %0d bal %0d err %b want 1 5 0 1", lat, code, bal, err); end
    endtask

    task automatic test_load_priority();
        int seen = 0;
        @(negedge clk);
        load_en = 1'b1; load_idx = 4'd5; load_acc = 12'd273; load_pin = 4'd2;
        req_valid = 1'b1; req_op = BALANCE; req_acc = 12'd273; req_pin = 4'd2; req_amount = '0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_ready got %b want 0", req_ready); end
        @(posedge clk); #1;
        load_en = 1'b0; req_valid = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL load_req_dropped got %0d responses want 0", seen); end
        send(BALANCE, 12'd273, 4'd2, 12'd0, 11'd0);
        checks++; if (lat !== 7 || code !== 3'd0 || bal !== 11'd500) begin errors++;
            $display("FAIL loaded_entry got lat %0d code %0d bal %0d want 7 0 500", lat, code, bal); end
        load(4'd9, 12'd999, 4'd1);
        send(FIND, 12'd999, 4'd1, 12'd0, 11'd0);
        checks++; if (lat !== 9 || code !== 3'd1) begin errors++;
            $display("FAIL load_idx_oob got lat %0d code %0d want 9 1", lat, code); end
    endtask

    task automatic test_busy_ignore();
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = WITHDRAW; req_acc = 12'd2178; req_pin = 4'd4; req_amount = 11'd10;
        @(posedge clk); #1;
        req_amount = 11'd20;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_code !== 3'd0 || rsp_balance !== 11'd340) begin errors++;
            $display("FAIL busy_first got v %b code %0d bal %0d want 1 0 340", rsp_valid, rsp_code, rsp_balance); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_balance !== 11'd340) begin errors++;
            $display("FAIL rsp_pulse_hold got v %b rdy %b bal %0d want 0 1 340", rsp_valid, req_ready, rsp_balance); end
        repeat (12) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL busy_second got %0d responses want 0", seen); end
        send(BALANCE, 12'd2178, 4'd4, 12'd0, 11'd0);
        checks++; if (code !== 3'd0 || bal !== 11'd340) begin errors++;
            $display("FAIL busy_balance got code %0d bal %0d want 0 340", code, bal); end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = TRANSFER; req_acc = 12'd2178; req_pin = 4'd4;
        req_dest = 12'd2816; req_amount = 11'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++;
            $display("FAIL abort_idle got rdy %b v %b want 1 0", req_ready, rsp_valid); end
        repeat (10) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp got %0d responses want 0", seen); end
        send(FIND, 12'd2178, 4'd4, 12'd0, 11'd0);
        checks++; if (lat !== 9 || code !== 3'd1 || bal !== 11'd0) begin errors++;
            $display("FAIL abort_table_cleared got lat %0d code %0d bal %0d want 9 1 0", lat, code, bal); end
    endtask

    task automatic test_overflow();
        load(4'd0, 12'd2178, 4'd4);
        load(4'd3, 12'd2816, 4'd6);
        send(TRANSFER, 12'd2816, 4'd6, 12'd2178, 11'd600);
        checks++; if (lat !== 6 || hi_code !== 3'd4 || hi_bal !== 11'd1500) begin errors++;
            $display("FAIL overflow got lat %0d code %0d bal %0d want 6 4 1500", lat, hi_code, hi_bal); end
        checks++; if (code !== 3'd3 || bal !== 11'd500) begin errors++;
            $display("FAIL transfer_insuff got code %0d bal %0d want 3 500", code, bal); end
        send(TRANSFER, 12'd2178, 4'd4, 12'd2178, 11'd10);
        checks++; if (lat !== 3 || hi_code !== 3'd6 || hi_bal !== 11'd1500) begin errors++;
            $display("FAIL same_account got lat %0d code %0d bal %0d want 3 6 1500", lat, hi_code, hi_bal); end
        send(BALANCE, 12'd2816, 4'd6, 12'd0, 11'd0);
        checks++; if (hi_code !== 3'd0 || hi_bal !== 11'd1500) begin errors++;
            $display("FAIL overflow_src_kept got code %0d bal %0d want 0 1500", hi_code, hi_bal); end
        send(BALANCE, 12'd2178, 4'd4, 12'd0, 11'd0);
        checks++; if (hi_code !== 3'd0 || hi_bal !== 11'd1500) begin errors++;
            $display("FAIL overflow_dst_kept got code %0d bal %0d want 0 1500", hi_code, hi_bal); end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_withdraw();
        test_transfer();
        test_bad_op();
        test_load_priority();
        test_busy_ignore();
        test_reset_abort();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
